// File: rtl/bcd_disp_mux_3_if.sv
// rtl/bcd_disp_mux_3_if.sv - BCD value in, multiplexed seven-segment drive out
interface bcd_disp_mux_3_if;
  logic [11:0] bcd;
  logic        overflow;
  logic        blank_lz;
  logic [3:0]  an;
  logic [7:0]  sseg;

  modport master (
    output bcd,
    output overflow,
    output blank_lz,
    input  an,
    input  sseg
  );

  modport slave (
    input  bcd,
    input  overflow,
    input  blank_lz,
    output an,
    output sseg
  );
endinterface

// File: rtl/bcd_disp_mux_3.sv
// rtl/bcd_disp_mux_3.sv - 4-digit common-anode scan driver for a 3-digit BCD value
// Inputs are snapshotted on the refresh wrap so one scan frame never mixes values.
module bcd_disp_mux_3 #(
  parameter int N = 18
) (
  input  logic              clk,
  input  logic              reset,
  bcd_disp_mux_3_if.slave   disp
);

  localparam logic [N-1:0] Q_MAX = '1;
  localparam logic [N-1:0] Q_ONE = {{(N-1){1'b0}}, 1'b1};

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ONE   = 8'hF9;
  localparam logic [7:0] SEG_ERR   = 8'h86;

  logic [N-1:0] q_q,        q_d;
  logic [11:0]  snap_bcd_q, snap_bcd_d;
  logic         snap_ov_q,  snap_ov_d;
  logic [3:0]   an_q,       an_d;
  logic [7:0]   sseg_q,     sseg_d;

  logic [1:0]   sel;
  logic         wrap;
  logic [3:0]   nib;
  logic         blank;
  logic         hund_zero;
  logic         tens_zero;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  always_comb begin
    sel  = q_q[N-1:N-2];
    wrap = (q_q == Q_MAX);
    q_d  = q_q + Q_ONE;

    snap_bcd_d = wrap ? disp.bcd      : snap_bcd_q;
    snap_ov_d  = wrap ? disp.overflow : snap_ov_q;
  end

  // An invalid nibble (>9) is nonzero here, so it is never blanked.
  always_comb begin
    hund_zero = (snap_bcd_q[11:8] == 4'd0);
    tens_zero = (snap_bcd_q[7:4]  == 4'd0);
    nib       = 4'd0;
    blank     = 1'b0;
    case (sel)
      2'd0: begin
        nib   = snap_bcd_q[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = snap_bcd_q[7:4];
        blank = disp.blank_lz && hund_zero && tens_zero;
      end
      2'd2: begin
        nib   = snap_bcd_q[11:8];
        blank = disp.blank_lz && hund_zero;
      end
      default: begin
        nib   = 4'd0;
        blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_d = ~(4'b0001 << sel);
    if (sel == 2'd3) begin
      sseg_d = snap_ov_q ? SEG_ONE : SEG_BLANK;
    end else if (blank) begin
      sseg_d = SEG_BLANK;
    end else begin
      sseg_d = seg_decode(nib);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q        <= '0;
      snap_bcd_q <= 12'h000;
      snap_ov_q  <= 1'b0;
      an_q       <= 4'b1111;
      sseg_q     <= SEG_BLANK;
    end else begin
      q_q        <= q_d;
      snap_bcd_q <= snap_bcd_d;
      snap_ov_q  <= snap_ov_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
    end
  end

  assign disp.an   = an_q;
  assign disp.sseg = sseg_q;

endmodule

// File: tb/tb_bcd_disp_mux_3.sv
// tb/tb_bcd_disp_mux_3.sv - directed scoreboard bench for bcd_disp_mux_3 with N=4
module tb_bcd_disp_mux_3;

  logic clk;
  logic reset;
  int   edge_cnt;
  int   n_assert;
  int   n_fail;

  bcd_disp_mux_3_if dif();

  bcd_disp_mux_3 #(.N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (dif)
  );

  typedef struct {
    string      tag;
    int         at_edge;
    logic [3:0] an;
    logic [7:0] sseg;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  task automatic goto_edge(input int target);
    int guard;
    guard = 0;
    while (edge_cnt < target && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (edge_cnt != target) begin
      n_assert++;
      n_fail++;
      $error("FAIL goto_edge observed=%0d expected=%0d", edge_cnt, target);
    end
  endtask

  task automatic push_one(input string tag, input int at_edge, input int slot, input logic [7:0] sseg);
    exp_t e;
    e.tag     = tag;
    e.at_edge = at_edge;
    e.an      = 4'b1111;
    e.an[slot] = 1'b0;
    e.sseg    = sseg;
    sb.push_back(e);
  endtask

  task automatic push_frame(input string tag, input int frame,
                            input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    push_one(tag, 16*frame + 1,  0, s0);
    push_one(tag, 16*frame + 5,  1, s1);
    push_one(tag, 16*frame + 9,  2, s2);
    push_one(tag, 16*frame + 13, 3, s3);
  endtask

  task automatic check_now(input string tag, input logic [3:0] ea, input logic [7:0] es);
    n_assert++;
    assert (dif.an === ea) else begin
      n_fail++;
      $error("FAIL %s an observed=%b expected=%b", tag, dif.an, ea);
    end
    n_assert++;
    assert (dif.sseg === es) else begin
      n_fail++;
      $error("FAIL %s sseg observed=%h expected=%h", tag, dif.sseg, es);
    end
  endtask

  task automatic check_next();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      goto_edge(e.at_edge);
      check_now(e.tag, e.an, e.sseg);
    end
  endtask

  task automatic check_frame();
    repeat (4) check_next();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset         = 1'b1;
    dif.bcd       = 12'h123;
    dif.overflow  = 1'b0;
    dif.blank_lz  = 1'b1;
    #3;
    check_now("reset_state", 4'b1111, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Frame 0 still shows the reset snapshot of 000.
    push_frame("frame0_zero", 0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    check_frame();

    push_frame("plain_123", 1, 8'hB0, 8'hA4, 8'hF9, 8'hFF);
    check_next();
    check_next();
    dif.bcd = 12'h999;
    check_next();
    check_next();

    push_frame("snap_999", 2, 8'h90, 8'h90, 8'h90, 8'hFF);
    check_frame();

    dif.bcd = 12'h007;
    push_frame("lz_on_007", 3, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
    check_frame();

    dif.blank_lz = 1'b0;
    push_frame("lz_off_007", 4, 8'hF8, 8'hC0, 8'hC0, 8'hFF);
    check_frame();

    dif.blank_lz = 1'b1;
    dif.bcd      = 12'h000;
    push_frame("lz_000", 5, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    check_frame();

    dif.bcd = 12'h0A0;
    push_frame("invalid_0a0", 6, 8'hC0, 8'h86, 8'hFF, 8'hFF);
    check_frame();

    dif.bcd      = 12'h000;
    dif.overflow = 1'b1;
    push_frame("overflow", 7, 8'hC0, 8'hFF, 8'hFF, 8'hF9);
    check_frame();

    // Change lands in the cycle just before the wrap edge and must be captured.
    dif.overflow = 1'b0;
    goto_edge(127);
    dif.bcd = 12'h456;
    push_frame("wrap_edge_456", 8, 8'h82, 8'h92, 8'h99, 8'hFF);
    check_next();
    dif.bcd = 12'h111;
    check_next();
    check_next();
    check_next();

    push_one("pre_reset_111", 153, 2, 8'hF9);
    check_next();
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset", 4'b1111, 8'hFF);
    @(negedge clk);
    reset = 1'b0;

    push_one("post_reset_units", 1, 0, 8'hC0);
    push_one("post_reset_tens",  5, 1, 8'hFF);
    push_one("post_reset_hund",  9, 2, 8'hFF);
    push_one("post_reset_ovf",  13, 3, 8'hFF);
    check_frame();

    push_frame("recapture_111", 1, 8'hF9, 8'hF9, 8'hF9, 8'hFF);
    check_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
